// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one combinational 32-bit ALU and returns each tagged
// result on a shared response channel. Opcodes the ALU leaves undefined are filtered out.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic              last_grant;
  logic              grant_any;
  logic              grant_id;
  logic              accept;
  logic              op_legal;
  logic [DATA_W-1:0] lat_a;
  logic [DATA_W-1:0] lat_b;
  logic [OP_W-1:0]   lat_op;
  logic              lat_id;

  // Grant selection; on a tie round-robin favours whoever did not win last time.
  always_comb begin
    grant_any = |req_valid;
    grant_id  = 1'b0;
    if (req_valid == 2'b10) begin
      grant_id = 1'b1;
    end else if (req_valid == 2'b11) begin
      grant_id = RR_EN ? ~last_grant : 1'b0;
    end
    req_ready = {grant_id, ~grant_id} & {2{(state == IDLE) && grant_any}};
    accept    = |(req_valid & req_ready);
  end

  always_comb begin
    op_legal = 1'b0;
    case (lat_op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b101: op_legal = 1'b1;
      default:                                op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand latch, round-robin history and response capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      lat_op     <= '0;
      lat_id     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        last_grant <= grant_id;
        lat_id     <= grant_id;
        lat_a      <= grant_id ? req1_a  : req0_a;
        lat_b      <= grant_id ? req1_b  : req0_b;
        lat_op     <= grant_id ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        rsp_id     <= lat_id;
        rsp_result <= op_legal ? alu_result : '0;
        rsp_zero   <= op_legal ? alu_zero : 1'b1;
        rsp_err    <= ~op_legal;
      end
      rsp_valid <= (state_next == RESP);
    end
  end

  // ALU inputs come straight from the latch, so they hold their last value outside EXEC.
  assign alu_a       = lat_a;
  assign alu_b       = lat_b;
  assign alu_control = lat_op;

endmodule
